// File: rtl/debug_pkg.sv
// Shared definitions for the debug clock-gating control path: command opcodes,
// controller state encoding and the default step-count width.
package debug_pkg;

    localparam int DEF_STEP_W = 3;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

endpackage

// File: rtl/debug_step_ctrl.sv
// Command-driven run/halt/step controller feeding the debug clock gater.
// Optional retired-step counter enabled by defining DEBUG_STEP_CTRL_TOTAL_EN.
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int STEP_W  = DEF_STEP_W,
    parameter int TOTAL_W = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [STEP_W-1:0]  cmd_count,
    output logic               cmd_err,
    output logic               debug_en,
    output logic               stepinto_en,
    output logic [STEP_W-1:0]  stepvalue,
    output logic               busy,
    output logic               step_done,
    output logic [TOTAL_W-1:0] steps_total
);

    localparam logic [STEP_W:0] REM_ONE = {{STEP_W{1'b0}}, 1'b1};

    state_e            r_state;
    logic              r_cmd_ready;
    logic              r_cmd_err;
    logic              r_debug_en;
    logic              r_stepinto_en;
    logic [STEP_W-1:0] r_stepvalue;
    logic [STEP_W:0]   r_rem;
    logic              r_busy;
    logic              r_step_done;
    logic              w_step_fin;

    assign w_step_fin = (r_state == ST_STEP) && (r_rem == REM_ONE);

    // rem = N+1 so stepinto_en spans N+1 cycles, absorbing the gater's select lag.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_cmd_ready   <= 1'b1;
            r_cmd_err     <= 1'b0;
            r_debug_en    <= 1'b0;
            r_stepinto_en <= 1'b0;
            r_stepvalue   <= '0;
            r_rem         <= '0;
            r_busy        <= 1'b0;
            r_step_done   <= 1'b0;
        end else begin
            r_cmd_err   <= 1'b0;
            r_step_done <= 1'b0;
            case (r_state)
                ST_RUN, ST_HALTED: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_RUN: begin
                                r_state    <= ST_RUN;
                                r_debug_en <= 1'b0;
                            end
                            OP_HALT: begin
                                r_state    <= ST_HALTED;
                                r_debug_en <= 1'b1;
                            end
                            OP_STEP: begin
                                if (r_state == ST_HALTED) begin
                                    r_state     <= ST_LOAD;
                                    r_stepvalue <= cmd_count;
                                    r_rem       <= {1'b0, cmd_count} + REM_ONE;
                                    r_busy      <= 1'b1;
                                    r_cmd_ready <= 1'b0;
                                end else begin
                                    r_cmd_err <= 1'b1;
                                end
                            end
                            default: r_cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD: begin
                    r_state       <= ST_STEP;
                    r_stepinto_en <= 1'b1;
                end
                ST_STEP: begin
                    r_rem <= r_rem - REM_ONE;
                    if (w_step_fin) begin
                        r_state       <= ST_HALTED;
                        r_stepinto_en <= 1'b0;
                        r_busy        <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_step_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_RUN;
                    r_debug_en    <= 1'b0;
                    r_stepinto_en <= 1'b0;
                    r_busy        <= 1'b0;
                    r_cmd_ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef DEBUG_STEP_CTRL_TOTAL_EN
    localparam int SUM_W = ((TOTAL_W > STEP_W) ? TOTAL_W : STEP_W) + 1;

    logic [TOTAL_W-1:0] r_total;
    logic [SUM_W-1:0]   w_sum;

    assign w_sum = SUM_W'(r_total) + SUM_W'(r_stepvalue);

    // Saturating accumulate; never wraps back through zero.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_total <= '0;
        end else if (w_step_fin) begin
            r_total <= (w_sum > SUM_W'({TOTAL_W{1'b1}})) ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
        end
    end

    assign steps_total = r_total;
`else
    assign steps_total = '0;
`endif

    assign cmd_ready   = r_cmd_ready;
    assign cmd_err     = r_cmd_err;
    assign debug_en    = r_debug_en;
    assign stepinto_en = r_stepinto_en;
    assign stepvalue   = r_stepvalue;
    assign busy        = r_busy;
    assign step_done   = r_step_done;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scoreboard bench for debug_step_ctrl: timeline reference model predicts every
// post-edge output set, a negedge monitor pops and compares.
module tb_debug_step_ctrl;
    localparam int STEP_W  = 3;
    localparam int TOTAL_W = 4;
    localparam int TMAX    = (1 << TOTAL_W) - 1;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [STEP_W-1:0] cmd_count = '0;
    logic              cmd_err;
    logic              debug_en;
    logic              stepinto_en;
    logic [STEP_W-1:0] stepvalue;
    logic              busy;
    logic              step_done;
    logic [TOTAL_W-1:0] steps_total;

    debug_step_ctrl #(.STEP_W(STEP_W), .TOTAL_W(TOTAL_W)) dut (
        .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_err(cmd_err),
        .debug_en(debug_en), .stepinto_en(stepinto_en), .stepvalue(stepvalue),
        .busy(busy), .step_done(step_done), .steps_total(steps_total)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int e;
        bit ready, err, den, si, busy, done;
        int sv, total;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: one optional active step described by its accept edge and N.
    int e_cnt = 0;
    bit m_halted = 0;
    bit m_active = 0;
    int m_k = 0;
    int m_n = 0;
    int m_sv = 0;
    int m_total = 0;

    task automatic model_edge();
        exp_t r;
        bit err, done;
        e_cnt++;
        err = 0;
        done = 0;
        if (rst) begin
            m_halted = 0; m_active = 0; m_sv = 0; m_total = 0;
        end else if (m_active) begin
            if (e_cnt == m_k + m_n + 2) begin
                m_active = 0;
                m_halted = 1;
                done = 1;
                m_total = (m_total + m_n > TMAX) ? TMAX : m_total + m_n;
            end
        end else if (cmd_valid) begin
            case (int'(cmd_op))
                0: m_halted = 0;
                1: m_halted = 1;
                2: begin
                    if (m_halted) begin
                        m_active = 1; m_k = e_cnt; m_n = int'(cmd_count); m_sv = m_n;
                    end else err = 1;
                end
                default: err = 1;
            endcase
        end
        r.e = e_cnt;
        r.err = err;
        r.done = done;
        r.sv = m_sv;
`ifdef DEBUG_STEP_CTRL_TOTAL_EN
        r.total = m_total;
`else
        r.total = 0;
`endif
        if (m_active) begin
            r.den = 1; r.busy = 1; r.ready = 0;
            r.si = (e_cnt != m_k);
        end else begin
            r.den = m_halted; r.busy = 0; r.ready = 1; r.si = 0;
        end
        sb_q.push_back(r);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            model_edge();
        end
    endtask

    task automatic cmd(input bit v, input int op, input int cnt);
        cmd_valid = v;
        cmd_op = 2'(op);
        cmd_count = STEP_W'(cnt);
    endtask

    function automatic void chk(input string name, input int e, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, expv);
        end
    endfunction

    always @(negedge clk_in) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("cmd_ready",   x.e, int'(cmd_ready),   int'(x.ready));
            chk("cmd_err",     x.e, int'(cmd_err),     int'(x.err));
            chk("debug_en",    x.e, int'(debug_en),    int'(x.den));
            chk("stepinto_en", x.e, int'(stepinto_en), int'(x.si));
            chk("busy",        x.e, int'(busy),        int'(x.busy));
            chk("step_done",   x.e, int'(step_done),   int'(x.done));
            chk("stepvalue",   x.e, int'(stepvalue),   x.sv);
            chk("steps_total", x.e, int'(steps_total), x.total);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cmd(0, 0, 0);
        rst = 1;
        tick(2);
        rst = 0;
        // HALT then RUN
        cmd(1, 1, 0); tick(1); cmd(0, 0, 0); tick(2);
        cmd(1, 0, 0); tick(1); cmd(0, 0, 0); tick(2);
        // STEP while running, reserved op while halted
        cmd(1, 2, 4); tick(1); cmd(0, 0, 0); tick(1);
        cmd(1, 1, 0); tick(1);
        cmd(1, 3, 0); tick(1); cmd(0, 0, 0); tick(1);
        // STEP(5) and STEP(0)
        cmd(1, 2, 5); tick(1); cmd(0, 0, 0); tick(10);
        cmd(1, 2, 0); tick(1); cmd(0, 0, 0); tick(5);
        // reset in the middle of a step
        cmd(1, 2, 6); tick(1); cmd(0, 0, 0); tick(5);
        rst = 1; tick(1); rst = 0; tick(2);
        // back-to-back STEP(7) held valid, drives the counter into saturation
        cmd(1, 1, 0); tick(1);
        cmd(1, 2, 7); tick(40); cmd(0, 0, 0); tick(3);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cmd($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7));
            tick(1);
        end
        rst = 0;
        cmd(0, 0, 0);
        tick(2);
        @(negedge clk_in);
        #1;
        chk("scoreboard_drained", e_cnt, sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
